// File: rtl/parking_fee_collector.sv
// ---------------------------------------------------------------------------
// parking_fee_collector
//
// Turns a parked duration (timer ticks, reported at checkout) into a charge,
// collects coins, pays out change or a refund and pulses the exit gate.
// Only one transaction is in flight; a new duration is taken in IDLE only.
//
// Charge: the first FREE_TICKS ticks are free.  The remainder is billed in
// blocks of TICKS_PER_BLOCK ticks (a partial block counts as a whole block)
// at RATE units per block, saturating at CHARGE_MAX.
//
// Optional feature, macro PAY_TIMEOUT_EN:
//   defined   - PAY_TIMEOUT cycles in PAY without a coin behave exactly like
//               cancel (full refund, gate stays shut).  Each coin restarts
//               the count.
//   undefined - PAY waits for coins indefinitely; no timeout counter exists.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   fee_valid, fee new checkout duration (11-bit ticks), accepted in IDLE only
//   coin_valid     one strobe per coin, value from coin_sel
//   coin_sel       00=1, 01=5, 10=10, 11=20 units
//   cancel         user abort, refunds everything paid so far
//   amount_due     charge of the current/last transaction
//   amount_paid    running coin total of the current/last transaction
//   change_valid   one-cycle strobe qualifying change_out
//   change_out     change (paid-due) or refund (paid)
//   gate_open      exit gate drive, OPEN_CYCLES cycles long
//   busy           high whenever the FSM is not in IDLE
//   state_dbg      current FSM state encoding (IDLE=0 CALC=1 PAY=2
//                  CHANGE=3 OPEN=4)
//
// Handshake: every *_valid input is a single-cycle strobe sampled on the
// rising edge; there is no ready/back-pressure.  A strobe that arrives in a
// state that does not consume it is simply dropped.  change_valid is a
// single-cycle output strobe with the same meaning.
// ---------------------------------------------------------------------------
module parking_fee_collector #(
    parameter int FREE_TICKS      = 15,
    parameter int TICKS_PER_BLOCK = 60,
    parameter int RATE            = 20,
    parameter int CHARGE_W        = 12,
    parameter int CHARGE_MAX      = 500,
    parameter int OPEN_CYCLES     = 4,
    parameter int PAY_TIMEOUT     = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fee_valid,
    input  logic [10:0]         fee,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    output logic [CHARGE_W-1:0] amount_due,
    output logic [CHARGE_W-1:0] amount_paid,
    output logic                change_valid,
    output logic [CHARGE_W-1:0] change_out,
    output logic                gate_open,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_PAY    = 3'd2,
        S_CHANGE = 3'd3,
        S_OPEN   = 3'd4
    } state_t;

    localparam int OPEN_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    localparam logic [10:0]         FREE_T   = 11'(FREE_TICKS);
    localparam logic [10:0]         TPB      = 11'(TICKS_PER_BLOCK);
    localparam logic [CHARGE_W:0]   RATE_X   = (CHARGE_W+1)'(RATE);
    localparam logic [CHARGE_W:0]   CMAX_X   = (CHARGE_W+1)'(CHARGE_MAX);
    localparam logic [CHARGE_W-1:0] CMAX     = CHARGE_W'(CHARGE_MAX);
    localparam logic [OPEN_W-1:0]   OPEN_END = OPEN_W'(OPEN_CYCLES - 1);

    // Coin value, one bit wider than the totals so the carry shows overflow.
    function automatic logic [CHARGE_W:0] coin_value(input logic [1:0] sel);
        logic [CHARGE_W:0] v;
        case (sel)
            2'b00:   v = (CHARGE_W+1)'(1);
            2'b01:   v = (CHARGE_W+1)'(5);
            2'b10:   v = (CHARGE_W+1)'(10);
            default: v = (CHARGE_W+1)'(20);
        endcase
        return v;
    endfunction

    state_t              state_q, state_d;
    logic [10:0]         rem_q, rem_d;
    logic [CHARGE_W-1:0] due_q, due_d;
    logic [CHARGE_W-1:0] paid_q, paid_d;
    logic                refund_q, refund_d;
    logic                change_valid_q, change_valid_d;
    logic [CHARGE_W-1:0] change_out_q, change_out_d;
    logic                gate_q, gate_d;
    logic [OPEN_W-1:0]   open_cnt_q, open_cnt_d;

    logic [CHARGE_W:0]   due_sum;
    logic [CHARGE_W-1:0] due_sat;
    logic [CHARGE_W:0]   paid_sum;
    logic [CHARGE_W-1:0] paid_sat;
    logic                tmo_hit;
    logic                abort;

`ifdef PAY_TIMEOUT_EN
    localparam int TMO_W = $clog2(PAY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(PAY_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // tmo_q counts coin-less PAY cycles already seen; the PAY_TIMEOUT-th
    // idle cycle is the one that aborts.
    assign tmo_hit = (state_q == S_PAY) && !coin_valid && (tmo_q == TMO_END);
`else
    assign tmo_hit = 1'b0;
`endif

    assign abort = cancel || tmo_hit;

    // Saturating block charge and saturating coin total.
    assign due_sum  = {1'b0, due_q} + RATE_X;
    assign due_sat  = (due_sum > CMAX_X) ? CMAX : due_sum[CHARGE_W-1:0];
    assign paid_sum = {1'b0, paid_q} + coin_value(coin_sel);
    assign paid_sat = paid_sum[CHARGE_W] ? {CHARGE_W{1'b1}} : paid_sum[CHARGE_W-1:0];

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        due_d          = due_q;
        paid_d         = paid_q;
        refund_d       = refund_q;
        change_valid_d = 1'b0;
        change_out_d   = change_out_q;
        gate_d         = gate_q;
        open_cnt_d     = open_cnt_q;
`ifdef PAY_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (fee_valid) begin
                    rem_d    = (fee > FREE_T) ? (fee - FREE_T) : 11'd0;
                    due_d    = '0;
                    paid_d   = '0;
                    refund_d = 1'b0;
                    state_d  = S_CALC;
                end
            end

            // One billed block per cycle until the remaining time is used up.
            S_CALC: begin
                if (rem_q == 11'd0) begin
                    if (due_q == '0) begin
                        state_d    = S_OPEN;
                        gate_d     = 1'b1;
                        open_cnt_d = '0;
                    end else begin
                        state_d = S_PAY;
`ifdef PAY_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end else begin
                    due_d = due_sat;
                    rem_d = (rem_q > TPB) ? (rem_q - TPB) : 11'd0;
                end
            end

            // A coin arriving together with cancel is part of the refund, so
            // change_out is taken from paid_d, not paid_q.
            S_PAY: begin
                if (coin_valid) begin
                    paid_d = paid_sat;
                end
`ifdef PAY_TIMEOUT_EN
                if (coin_valid) begin
                    tmo_d = '0;
                end else if (tmo_q != TMO_END) begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
                if (abort) begin
                    state_d        = S_CHANGE;
                    refund_d       = 1'b1;
                    change_valid_d = 1'b1;
                    change_out_d   = paid_d;
                end else if (paid_q >= due_q) begin
                    state_d        = S_CHANGE;
                    refund_d       = 1'b0;
                    change_valid_d = 1'b1;
                    change_out_d   = paid_d - due_q;
                end
            end

            // Change strobe is visible during this state; coins/cancel ignored.
            S_CHANGE: begin
                if (refund_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_OPEN;
                    gate_d     = 1'b1;
                    open_cnt_d = '0;
                end
            end

            S_OPEN: begin
                if (open_cnt_q == OPEN_END) begin
                    state_d = S_IDLE;
                    gate_d  = 1'b0;
                end else begin
                    open_cnt_d = open_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rem_q          <= '0;
            due_q          <= '0;
            paid_q         <= '0;
            refund_q       <= 1'b0;
            change_valid_q <= 1'b0;
            change_out_q   <= '0;
            gate_q         <= 1'b0;
            open_cnt_q     <= '0;
`ifdef PAY_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            due_q          <= due_d;
            paid_q         <= paid_d;
            refund_q       <= refund_d;
            change_valid_q <= change_valid_d;
            change_out_q   <= change_out_d;
            gate_q         <= gate_d;
            open_cnt_q     <= open_cnt_d;
`ifdef PAY_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign amount_due   = due_q;
    assign amount_paid  = paid_q;
    assign change_valid = change_valid_q;
    assign change_out   = change_out_q;
    assign gate_open    = gate_q;
    assign busy         = (state_q != S_IDLE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_parking_fee_collector.sv
// ---------------------------------------------------------------------------
// tb_parking_fee_collector
//
// Directed bench for parking_fee_collector with default parameters.
// Expected values are worked out by hand from the charging rules:
//   rem = fee - 15 (or 0), blocks = ceil(rem / 60), due = min(20*blocks, 500)
//   fee_valid -> PAY takes 2 + blocks edges; free exit opens the gate 2 edges
//   after the strobe for 4 cycles.
// State encoding on state_dbg: IDLE=0 CALC=1 PAY=2 CHANGE=3 OPEN=4.
// ---------------------------------------------------------------------------
module tb_parking_fee_collector;

    localparam int CW = 12;

    localparam logic [31:0] ST_IDLE   = 32'd0;
    localparam logic [31:0] ST_CALC   = 32'd1;
    localparam logic [31:0] ST_PAY    = 32'd2;
    localparam logic [31:0] ST_CHANGE = 32'd3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          fee_valid;
    logic [10:0]   fee;
    logic          coin_valid;
    logic [1:0]    coin_sel;
    logic          cancel;
    logic [CW-1:0] amount_due;
    logic [CW-1:0] amount_paid;
    logic          change_valid;
    logic [CW-1:0] change_out;
    logic          gate_open;
    logic          busy;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    parking_fee_collector dut (
        .clk          (clk),
        .reset        (reset),
        .fee_valid    (fee_valid),
        .fee          (fee),
        .coin_valid   (coin_valid),
        .coin_sel     (coin_sel),
        .cancel       (cancel),
        .amount_due   (amount_due),
        .amount_paid  (amount_paid),
        .change_valid (change_valid),
        .change_out   (change_out),
        .gate_open    (gate_open),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_fee(input logic [10:0] f);
        fee_valid = 1'b1;
        fee       = f;
        tick();
        fee_valid = 1'b0;
        fee       = '0;
    endtask

    task automatic put_coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel   = sel;
        tick();
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
    endtask

    // Counts cycles the gate stays high (bounded) and whether a change
    // strobe appeared meanwhile.
    task automatic count_gate(input string tag, input int exp_len);
        int n;
        logic saw_cv;
        n      = 0;
        saw_cv = 1'b0;
        while (gate_open === 1'b1 && n < 20) begin
            if (change_valid === 1'b1) saw_cv = 1'b1;
            n++;
            tick();
        end
        check({tag, "_gate_len"}, n, exp_len);
        check({tag, "_no_cv_in_open"}, {31'd0, saw_cv}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        fee_valid  = 1'b0;
        fee        = '0;
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
        cancel     = 1'b0;
        ticks(3);

        // Reset state
        check("rst_state", {29'd0, state_dbg}, ST_IDLE);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gate", {31'd0, gate_open}, 32'd0);
        check("rst_cv", {31'd0, change_valid}, 32'd0);
        check("rst_due", {20'd0, amount_due}, 32'd0);
        check("rst_paid", {20'd0, amount_paid}, 32'd0);
        check("rst_chg", {20'd0, change_out}, 32'd0);
        reset = 1'b0;
        tick();

        // Free exit: fee=10 inside grace period
        start_fee(11'd10);
        check("free_busy", {31'd0, busy}, 32'd1);
        check("free_gate_early", {31'd0, gate_open}, 32'd0);
        tick();
        check("free_gate_at2", {31'd0, gate_open}, 32'd1);
        check("free_due", {20'd0, amount_due}, 32'd0);
        count_gate("free", 4);

        // fee=136: 3 blocks, due 60, exact payment
        start_fee(11'd136);
        ticks(3);
        check("e136_still_calc", {29'd0, state_dbg}, ST_CALC);
        tick();
        check("e136_pay", {29'd0, state_dbg}, ST_PAY);
        check("e136_due", {20'd0, amount_due}, 32'd60);
        put_coin(2'b11);
        check("e136_paid1", {20'd0, amount_paid}, 32'd20);
        put_coin(2'b11);
        put_coin(2'b11);
        check("e136_paid3", {20'd0, amount_paid}, 32'd60);
        check("e136_no_cv_yet", {31'd0, change_valid}, 32'd0);
        tick();
        check("e136_cv", {31'd0, change_valid}, 32'd1);
        check("e136_chg", {20'd0, change_out}, 32'd0);
        tick();
        check("e136_cv_once", {31'd0, change_valid}, 32'd0);
        check("e136_gate", {31'd0, gate_open}, 32'd1);
        count_gate("e136", 4);

        // fee=20: 1 block, due 20; pay 5+20, change 5
        start_fee(11'd20);
        ticks(2);
        check("e20_pay", {29'd0, state_dbg}, ST_PAY);
        check("e20_due", {20'd0, amount_due}, 32'd20);
        put_coin(2'b01);
        put_coin(2'b11);
        check("e20_paid", {20'd0, amount_paid}, 32'd25);
        tick();
        check("e20_cv", {31'd0, change_valid}, 32'd1);
        check("e20_chg", {20'd0, change_out}, 32'd5);
        // coin during CHANGE must be ignored
        put_coin(2'b11);
        check("e20_coin_in_change", {20'd0, amount_paid}, 32'd25);
        check("e20_gate", {31'd0, gate_open}, 32'd1);
        count_gate("e20", 4);
        check("e20_due_hold", {20'd0, amount_due}, 32'd20);
        check("e20_paid_hold", {20'd0, amount_paid}, 32'd25);

        // fee=76: 2 blocks, due 40; coin then coin+cancel -> refund 40
        start_fee(11'd76);
        ticks(3);
        check("e76_pay", {29'd0, state_dbg}, ST_PAY);
        check("e76_due", {20'd0, amount_due}, 32'd40);
        put_coin(2'b11);
        coin_valid = 1'b1;
        coin_sel   = 2'b11;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check("e76_state_chg", {29'd0, state_dbg}, ST_CHANGE);
        check("e76_cv", {31'd0, change_valid}, 32'd1);
        check("e76_refund", {20'd0, change_out}, 32'd40);
        check("e76_paid", {20'd0, amount_paid}, 32'd40);
        begin
            logic saw_gate;
            saw_gate = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (gate_open === 1'b1) saw_gate = 1'b1;
            end
            check("e76_no_gate", {31'd0, saw_gate}, 32'd0);
        end
        check("e76_idle", {29'd0, state_dbg}, ST_IDLE);

        // fee=2047: 34 blocks, due saturates at 500; extra fee_valid ignored
        start_fee(11'd2047);
        start_fee(11'd10);
        ticks(33);
        check("e2047_still_calc", {29'd0, state_dbg}, ST_CALC);
        tick();
        check("e2047_pay", {29'd0, state_dbg}, ST_PAY);
        check("e2047_due", {20'd0, amount_due}, 32'd500);
        start_fee(11'd10);
        check("e2047_fee_in_pay", {29'd0, state_dbg}, ST_PAY);
        check("e2047_due_kept", {20'd0, amount_due}, 32'd500);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("e2047_cv", {31'd0, change_valid}, 32'd1);
        check("e2047_refund", {20'd0, change_out}, 32'd0);
        tick();
        check("e2047_idle", {29'd0, state_dbg}, ST_IDLE);
        check("e2047_gate", {31'd0, gate_open}, 32'd0);

        // Reset in the middle of PAY drops the transaction
        start_fee(11'd136);
        ticks(4);
        put_coin(2'b10);
        check("mid_paid", {20'd0, amount_paid}, 32'd10);
        reset = 1'b1;
        tick();
        check("mid_rst_state", {29'd0, state_dbg}, ST_IDLE);
        check("mid_rst_due", {20'd0, amount_due}, 32'd0);
        check("mid_rst_paid", {20'd0, amount_paid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
